// File: rtl/kf_pkg.sv
// Shared DAC constants and code conversion helpers for the Kalman output paths.
package kf_pkg;
  localparam int DAC_W = 14;
  localparam logic [DAC_W-1:0] MID_CODE = 14'h1FFF;
  localparam logic [DAC_W-1:0] SAT_MAX = 14'h1FFF;
  localparam logic [DAC_W-1:0] SAT_MIN = 14'h2000;
  localparam int SAT_HI = 8191;
  localparam int SAT_LO = -8192;

  typedef struct packed {
    logic [DAC_W-1:0] dat;
    logic             sel;
    logic             wrt;
  } dac_bus_t;

  function automatic logic [DAC_W-1:0] sat_dac(input logic signed [31:0] v);
    if (v > SAT_HI) return SAT_MAX;
    else if (v < SAT_LO) return SAT_MIN;
    else return v[DAC_W-1:0];
  endfunction

  // The DAC wants sign bit kept and magnitude bits inverted, so zero lands on MID.
  function automatic logic [DAC_W-1:0] offset_inv(input logic [DAC_W-1:0] s);
    return {s[DAC_W-1], ~s[DAC_W-2:0]};
  endfunction

  function automatic logic [DAC_W-1:0] to_dac_code(input logic signed [31:0] v);
    return offset_inv(sat_dac(v));
  endfunction
endpackage

// File: rtl/kf_sat_shift.sv
// Arithmetic right shift and saturation of a signed sample down to the DAC width.
module kf_sat_shift
  import kf_pkg::*;
#(
  parameter int IN_WIDTH = 16,
  parameter int IN_SHIFT = 0
) (
  input  logic [IN_WIDTH-1:0] din,
  output logic [DAC_W-1:0]    dout
);
  logic signed [31:0] ext;
  logic signed [31:0] shd;

  assign ext  = {{(32-IN_WIDTH){din[IN_WIDTH-1]}}, din};
  assign shd  = ext >>> IN_SHIFT;
  assign dout = sat_dac(shd);
endmodule

// File: rtl/kf_dac_writer.sv
// Drives the Red Pitaya DAC with the Kalman estimate on channel A and the raw
// ADC sample on channel B, interleaved on alternate clock cycles.
module kf_dac_writer
  import kf_pkg::*;
#(
  parameter int IN_WIDTH       = 16,
  parameter int DAC_WIDTH      = 14,
  parameter int IN_SHIFT       = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [IN_WIDTH-1:0]  s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [DAC_WIDTH-1:0] raw_dat,
  input  logic                 raw_valid,
  output logic [DAC_WIDTH-1:0] dac_dat_o,
  output logic                 dac_sel_o,
  output logic                 dac_wrt_o,
  output logic                 dac_rst_o,
  output logic                 stale_o
);
  localparam logic [0:0] PH_A = 1'b0;
  localparam logic [0:0] PH_B = 1'b1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [0:0]       phase_q, phase_d;
  logic             buf_full_q, buf_full_d;
  logic [DAC_W-1:0] buf_q, buf_d;
  logic [DAC_W-1:0] hold_a_q, hold_a_d;
  logic [DAC_W-1:0] raw_b_q, raw_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stale_q, stale_d;
  logic             rst_q, rst_d;
  dac_bus_t         out_q, out_d;

  logic [DAC_W-1:0] est_sat, est_code;
  logic             accept;

  kf_sat_shift #(
    .IN_WIDTH(IN_WIDTH),
    .IN_SHIFT(IN_SHIFT)
  ) u_sat (
    .din (s_axis_tdata),
    .dout(est_sat)
  );

  assign est_code = offset_inv(est_sat);

  // rst_q doubles as the "not yet released" flag, so the first post-reset edge never accepts.
  assign s_axis_tready = aresetn & ~rst_q & (~buf_full_q | (phase_q == PH_A));
  assign accept        = s_axis_tvalid & s_axis_tready;

  always_comb begin
    phase_d    = ~phase_q;
    buf_full_d = buf_full_q;
    buf_d      = buf_q;
    hold_a_d   = hold_a_q;
    raw_b_d    = raw_b_q;
    cnt_d      = cnt_q;
    stale_d    = stale_q;
    rst_d      = ~aresetn;
    out_d      = out_q;

    if (raw_valid) raw_b_d = offset_inv(raw_dat);

    if (accept) begin
      cnt_d   = '0;
      stale_d = 1'b0;
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_MAX) stale_d = 1'b1;
    end

    if (phase_q == PH_A) begin
      out_d.sel = 1'b0;
      out_d.wrt = 1'b0;
      if (buf_full_q) begin
        out_d.dat  = buf_q;
        hold_a_d   = buf_q;
        buf_full_d = 1'b0;
      end else begin
        out_d.dat = stale_q ? MID_CODE : hold_a_q;
      end
    end else begin
      out_d.dat = raw_b_q;
      out_d.sel = 1'b1;
      out_d.wrt = 1'b1;
    end

    // Accept wins over drain so a same-edge refill keeps the buffer occupied.
    if (accept) begin
      buf_d      = est_code;
      buf_full_d = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      phase_q    <= PH_A;
      buf_full_q <= 1'b0;
      buf_q      <= MID_CODE;
      hold_a_q   <= MID_CODE;
      raw_b_q    <= MID_CODE;
      cnt_q      <= '0;
      stale_q    <= 1'b1;
      rst_q      <= 1'b1;
      out_q      <= '{dat: MID_CODE, sel: 1'b0, wrt: 1'b0};
    end else begin
      phase_q    <= phase_d;
      buf_full_q <= buf_full_d;
      buf_q      <= buf_d;
      hold_a_q   <= hold_a_d;
      raw_b_q    <= raw_b_d;
      cnt_q      <= cnt_d;
      stale_q    <= stale_d;
      rst_q      <= rst_d;
      out_q      <= out_d;
    end
  end

  assign dac_dat_o = out_q.dat;
  assign dac_sel_o = out_q.sel;
  assign dac_wrt_o = out_q.wrt;
  assign dac_rst_o = rst_q;
  assign stale_o   = stale_q;
endmodule

// File: doc/kf_dac_writer.md
Name: kf_dac_writer

Overview:
Output-side counterpart of the ADC capture path. Takes the 16-bit Kalman estimate stream and the raw 14-bit ADC sample and drives the Red Pitaya DAC interface. Channel A carries the estimate and channel B the raw measurement, interleaved on alternate aclk cycles, so the filtered and unfiltered signals are both visible on a scope. Sits between the Kalman filter core and the top-level dac_* pins.

Parameters:
IN_WIDTH, 16, width of the signed two's-complement estimate input
DAC_WIDTH, 14, DAC code width; fixed at 14 for this board
IN_SHIFT, 0, arithmetic right shift applied to the estimate before saturation (0..IN_WIDTH-DAC_WIDTH+2)
TIMEOUT_CYCLES, 1024, number of aclk cycles without an accepted estimate before channel A is forced to midscale

Ports:
aclk  in  1  single clock, rising edge
aresetn  in  1  synchronous, active-low reset
s_axis_tdata  in  IN_WIDTH  signed estimate sample
s_axis_tvalid  in  1  estimate valid
s_axis_tready  out  1  estimate accepted when tvalid&tready at the rising edge
raw_dat  in  14  signed raw ADC sample
raw_valid  in  1  raw sample valid
dac_dat_o  out  14  DAC code, offset-inverted format
dac_sel_o  out  1  0 = channel A code on dac_dat_o, 1 = channel B code
dac_wrt_o  out  1  one-cycle pulse marking a completed A/B pair
dac_rst_o  out  1  DAC reset
stale_o  out  1  no estimate accepted for TIMEOUT_CYCLES cycles

Behaviour:
- Conversion code(s): s = saturate(tdata >>> IN_SHIFT) to [-8192, 8191]; code = {s[13], ~s[12:0]}. Zero maps to MID = 14'h1FFF. Conversion happens on acceptance, and the buffer stores the 14-bit code.
- Reset values (while aresetn=0): dac_dat_o=MID, dac_sel_o=0, dac_wrt_o=0, dac_rst_o=1, stale_o=1, s_axis_tready=0, phase=0, buf_full=0, hold_a=MID, raw_b=MID, timeout counter=0.
- dac_rst_o is a register of ~aresetn: it is high during reset and goes low at the first edge after release.
- phase toggles every cycle after reset. The first edge after release is a phase-0 edge.
- One-entry buffer. s_axis_tready = aresetn_released & (~buf_full | phase==0), combinational from registers. Acceptance and drain in the same phase-0 edge are legal: the old entry goes out, the new one is stored, and buf_full stays 1.
- Phase-0 edge:
  - dac_sel_o<=0, dac_wrt_o<=0.
  - If buf_full: dac_dat_o<=buf, hold_a<=buf, buf_full<=0 (unless a simultaneous accept occurs).
  - Else: dac_dat_o<= stale ? MID : hold_a.
- Phase-1 edge: dac_dat_o<=raw_b, dac_sel_o<=1, dac_wrt_o<=1.
- Raw channel: raw_b<={raw_dat[13],~raw_dat[12:0]} at every edge with raw_valid=1; otherwise it holds. No handshake on the raw channel.
- Latency:
  - Accepted on a phase-1 edge with the buffer empty: appears on dac_dat_o 1 edge later.
  - Accepted on a phase-0 edge: appears 2 edges later.
  - Throughput is at most 1 estimate per 2 cycles. tready is low on phase 1 while buf_full.
- Timeout: the counter clears on every accept and otherwise increments, saturating at TIMEOUT_CYCLES-1.
  - stale_o sets at the edge where counter==TIMEOUT_CYCLES-1 and there is no accept.
  - stale_o clears at the edge where a sample is accepted.
  - While stale, channel A outputs MID; hold_a is retained but unused.
  - A buffered sample is never stale, because accepting it cleared stale.
- Reset mid-operation: all state returns to reset values at the next edge. A buffered sample is discarded, and a transfer in flight is not accepted (tready=0).

Decomposition:
- Shared package kf_pkg:
  - DAC_W=14 and MID_CODE=14'h1FFF.
  - Function to_dac_code (saturate plus offset-inversion), reused by any future DAC path.
- One sub-module, kf_sat_shift: combinational shift and saturate from IN_WIDTH to 14 bits. It is instantiated once for the estimate input.
- All sequential logic (phase, buffer, timeout, output registers) lives in kf_dac_writer.

Test Plan:
- Reset 5 cycles then release -> dac_rst_o 1 during reset and 0 one edge after; dac_dat_o=0x1FFF; stale_o=1; tready low during reset.
- tdata=16'h0123 accepted on a phase-1 edge, raw_dat=14'h0423 valid -> next edge dac_dat_o=0x1EDC, sel=0; following edge 0x1BDC, sel=1, wrt=1.
- Saturation: tdata=16'h7FFF -> channel A 0x0000; tdata=16'h8000 -> 0x3FFF; IN_SHIFT=2 with tdata=16'h0400 -> 0x1EFF.
- Back-to-back tvalid held high with incrementing data -> tready low on every phase-1 edge where buf_full; one sample per 2 cycles; no sample lost or duplicated on channel A.
- TIMEOUT_CYCLES=16: one accept then tvalid low -> stale_o rises exactly 16 edges after the accept and channel A reads 0x1FFF; the next accept of 16'h0123 clears stale_o at that edge and A=0x1EDC.
- aresetn pulsed low while buf_full -> buffered code never appears on dac_dat_o; outputs return to reset values at the next edge.
